// File: rtl/dacc_pkg.sv
// Shared encodings for the double-accumulator control path: opcodes, immediate
// extender selects, ALU operation codes and the controller state type.
package dacc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_BEQZ = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_6    = 2'b01;
    localparam logic [1:0] IMM_8    = 2'b10;
    localparam logic [1:0] IMM_10   = 2'b11;

    localparam logic [1:0] ALU_PASS_B = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_PASS_A = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_e;

endpackage

// File: rtl/dacc_imm_decode.sv
// Combinational immediate steering: picks the extender width from the opcode and
// presents the raw field zero-padded above that width.
module dacc_imm_decode
    import dacc_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int IMMW = 10
) (
    input  logic [OPW-1:0]  opcode,
    input  logic            acc_bit,
    input  logic [9:0]      imm_raw,
    output logic [1:0]      imm_sel,
    output logic [IMMW-1:0] imm_field,
    output logic            acc_sel
);

    always_comb begin
        imm_sel   = IMM_NONE;
        imm_field = '0;
        acc_sel   = acc_bit;
        case (opcode)
            OP_ADDI, OP_LDI: begin
                imm_sel        = IMM_8;
                imm_field[7:0] = imm_raw[7:0];
            end
            OP_LD, OP_ST: begin
                imm_sel        = IMM_6;
                imm_field[5:0] = imm_raw[5:0];
            end
            OP_BEQZ, OP_JMP: begin
                imm_sel        = IMM_10;
                imm_field[9:0] = imm_raw;
            end
            default: begin
                imm_sel   = IMM_NONE;
                imm_field = '0;
            end
        endcase
    end

endmodule

// File: rtl/dacc_imm_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller for the double-accumulator core.
// Strobes are Mealy/Moore outputs of the state register, forced low while rst_n is low.
module dacc_imm_ctrl_fsm
    import dacc_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int IMMW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_ready,
    input  logic [15:0]     mem_rdata,
    input  logic            acc_zero,
    output logic            mem_req,
    output logic            mem_we,
    output logic            ir_we,
    output logic [1:0]      imm_sel,
    output logic [IMMW-1:0] imm_field,
    output logic            acc_sel,
    output logic [1:0]      alu_op,
    output logic            acc_we,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            halted,
    output logic            illegal
);

    state_e         state_q, state_d;
    // Bit 10 of the instruction carries no meaning in this ISA, so it is not kept.
    logic [OPW-1:0] ir_op_q, ir_op_d;
    logic           ir_acc_q, ir_acc_d;
    logic [9:0]     ir_imm_q, ir_imm_d;
    logic [OPW-1:0] op_q, op_d;

    logic           fsm_mem_req, fsm_mem_we, fsm_ir_we, fsm_acc_we;
    logic           fsm_pc_inc, fsm_pc_load, fsm_halted, fsm_illegal;
    logic [1:0]     fsm_alu_op;
    logic [1:0]     dec_imm_sel;
    logic [IMMW-1:0] dec_imm_field;
    logic           dec_acc_sel;
    logic           imm_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            ir_op_q  <= '0;
            ir_acc_q <= 1'b0;
            ir_imm_q <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            ir_op_q  <= ir_op_d;
            ir_acc_q <= ir_acc_d;
            ir_imm_q <= ir_imm_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_op_d     = ir_op_q;
        ir_acc_d    = ir_acc_q;
        ir_imm_d    = ir_imm_q;
        op_d        = op_q;
        fsm_mem_req = 1'b0;
        fsm_mem_we  = 1'b0;
        fsm_ir_we   = 1'b0;
        fsm_acc_we  = 1'b0;
        fsm_pc_inc  = 1'b0;
        fsm_pc_load = 1'b0;
        fsm_halted  = 1'b0;
        fsm_illegal = 1'b0;
        fsm_alu_op  = ALU_PASS_B;
        case (state_q)
            S_FETCH: begin
                fsm_mem_req = 1'b1;
                if (mem_ready) begin
                    fsm_ir_we  = 1'b1;
                    fsm_pc_inc = 1'b1;
                    ir_op_d    = mem_rdata[15 -: OPW];
                    ir_acc_d   = mem_rdata[11];
                    ir_imm_d   = mem_rdata[9:0];
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = ir_op_q;
                case (ir_op_q)
                    OP_NOP:  state_d = S_FETCH;
                    OP_HALT: state_d = S_HALT;
                    OP_ADDI, OP_LDI, OP_LD, OP_ST, OP_BEQZ, OP_JMP: state_d = S_EXEC;
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_ADDI: begin
                        fsm_alu_op = ALU_ADD;
                        fsm_acc_we = 1'b1;
                    end
                    OP_LDI:        fsm_acc_we  = 1'b1;
                    OP_LD, OP_ST:  state_d     = S_MEM;
                    OP_JMP:        fsm_pc_load = 1'b1;
                    OP_BEQZ:       fsm_pc_load = acc_zero;
                    default:       state_d     = S_TRAP;
                endcase
            end
            S_MEM: begin
                fsm_mem_req = 1'b1;
                fsm_mem_we  = (op_q == OP_ST);
                if (mem_ready) begin
                    state_d = (op_q == OP_LD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                fsm_acc_we = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:  fsm_halted  = 1'b1;
            S_TRAP:  fsm_illegal = 1'b1;
            default: state_d     = S_FETCH;
        endcase
    end

    dacc_imm_decode #(
        .OPW  (OPW),
        .IMMW (IMMW)
    ) u_imm_decode (
        .opcode    (ir_op_q),
        .acc_bit   (ir_acc_q),
        .imm_raw   (ir_imm_q),
        .imm_sel   (dec_imm_sel),
        .imm_field (dec_imm_field),
        .acc_sel   (dec_acc_sel)
    );

    // The immediate belongs to the instruction in IR, so it is hidden while the next one is fetched.
    assign imm_valid = rst_n && (state_q != S_FETCH);

    assign mem_req   = rst_n & fsm_mem_req;
    assign mem_we    = rst_n & fsm_mem_we;
    assign ir_we     = rst_n & fsm_ir_we;
    assign acc_we    = rst_n & fsm_acc_we;
    assign pc_inc    = rst_n & fsm_pc_inc;
    assign pc_load   = rst_n & fsm_pc_load;
    assign halted    = rst_n & fsm_halted;
    assign illegal   = rst_n & fsm_illegal;
    assign alu_op    = rst_n ? fsm_alu_op : ALU_PASS_B;
    assign acc_sel   = rst_n & dec_acc_sel;
    assign imm_sel   = imm_valid ? dec_imm_sel : IMM_NONE;
    assign imm_field = imm_valid ? dec_imm_field : '0;

endmodule
